// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared state encoding and CRC-8 step for the configuration chain loader
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // MSB-first serial CRC-8, one input bit per call
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_crc8.sv
// rtl/ccff_crc8.sv - single-bit CRC-8 update register with synchronous clear and enable
module ccff_crc8
  import ccff_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = crc8_step(crc_q, din);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serialises bitstream words into a configuration chain with optional CRC readback
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 18,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              cfg_start,
  input  logic              cfg_verify_en,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(WORD_W + 1);

  localparam logic [CW-1:0] LAST_CNT  = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [BW-1:0] BUF_FULL  = BW'(WORD_W);
  localparam logic [BW-1:0] BUF_ONE   = BW'(1);

  state_e            state_q, state_d;
  logic              verify_q, verify_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [BW-1:0]     buf_cnt_q, buf_cnt_d;
  logic              prog_clk_en_q, prog_clk_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic       crc_clr;
  logic       shift_ld;
  logic       last_ld;
  logic       take;
  logic [7:0] crc_ld;
  logic [7:0] crc_rb;

  // prog_clk_en_q is precomputed for the coming cycle, so it doubles as "buffer is shifting"
  assign shift_ld = (state_q == ST_LOAD) && prog_clk_en_q;
  assign last_ld  = shift_ld && (cnt_q == LAST_CNT);

  // Refill while the final buffered bit shifts out, but never on the last chain bit
  assign cfg_ready = (state_q == ST_LOAD) &&
                     ((buf_cnt_q == '0) ||
                      ((buf_cnt_q == BUF_ONE) && prog_clk_en_q && (cnt_q != LAST_CNT)));
  assign take      = cfg_valid && cfg_ready;

  assign ccff_head = prog_clk_en_q & ((state_q == ST_VERIFY) ? ccff_tail : buf_q[0]);

  always_comb begin
    state_d   = state_q;
    verify_d  = verify_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    err_d     = err_q;
    crc_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d   = ST_LOAD;
          verify_d  = cfg_verify_en;
          cnt_d     = '0;
          buf_d     = '0;
          buf_cnt_d = '0;
          err_d     = 1'b0;
          crc_clr   = 1'b1;
        end
      end

      ST_LOAD: begin
        if (last_ld) begin
          cnt_d     = '0;
          buf_d     = '0;
          buf_cnt_d = '0;
          state_d   = verify_q ? ST_VERIFY : ST_DONE;
        end else begin
          if (shift_ld) begin
            buf_d     = buf_q >> 1;
            buf_cnt_d = buf_cnt_q - BUF_ONE;
            cnt_d     = cnt_q + CNT_ONE;
          end
          if (take) begin
            buf_d     = cfg_data;
            buf_cnt_d = BUF_FULL;
          end
        end
      end

      ST_VERIFY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          // Fold in the final returned bit so err is valid alongside done
          err_d   = verify_q && (crc8_step(crc_rb, ccff_tail) != crc_ld);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    prog_clk_en_d = ((state_d == ST_LOAD) && (buf_cnt_d != '0)) || (state_d == ST_VERIFY);
    busy_d        = (state_d == ST_LOAD) || (state_d == ST_VERIFY);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q       <= ST_IDLE;
      verify_q      <= 1'b0;
      cnt_q         <= '0;
      buf_q         <= '0;
      buf_cnt_q     <= '0;
      prog_clk_en_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      verify_q      <= verify_d;
      cnt_q         <= cnt_d;
      buf_q         <= buf_d;
      buf_cnt_q     <= buf_cnt_d;
      prog_clk_en_q <= prog_clk_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  ccff_crc8 u_crc_ld (
    .clk   (prog_clk),
    .rst_n (prog_reset_n),
    .clr   (crc_clr),
    .en    (shift_ld),
    .din   (buf_q[0]),
    .crc   (crc_ld)
  );

  ccff_crc8 u_crc_rb (
    .clk   (prog_clk),
    .rst_n (prog_reset_n),
    .clr   (crc_clr),
    .en    (state_q == ST_VERIFY),
    .din   (ccff_tail),
    .crc   (crc_rb)
  );

  assign prog_clk_en = prog_clk_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - bench for ccff_chain_loader with an 18-flop chain model
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 18;
  localparam int WORD_W    = 8;

  logic              prog_clk;
  logic              prog_reset_n;
  logic              cfg_start;
  logic              cfg_verify_en;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              ccff_tail;
  logic              prog_clk_en;
  logic              busy;
  logic              done;
  logic              err;

  logic [CHAIN_LEN-1:0] chain;
  logic                 stuck;

  int n_cmp  = 0;
  int n_fail = 0;
  bit last_err;

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .cfg_start     (cfg_start),
    .cfg_verify_en (cfg_verify_en),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .prog_clk_en   (prog_clk_en),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Behavioural chain: head enters the top, tail is bit 0
  initial chain = '0;
  always @(posedge prog_clk) begin
    if (prog_clk_en) chain <= {ccff_head, chain[CHAIN_LEN-1:1]};
  end
  assign ccff_tail = stuck ? 1'b1 : chain[0];

  typedef struct {
    logic [7:0]  w0, w1, w2;
    int          g0, g1, g2;
    bit          verify;
    bit          fault;
    bit          busy_start;
    int          exp_done;
    logic [17:0] exp_chain;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: CRC-8 poly 0x07 over the first CHAIN_LEN bits, bit 0 first
  function automatic logic [7:0] model_crc(input logic [17:0] bits);
    logic [8:0] c;
    c = 9'd0;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      c = {c[7:0], 1'b0} ^ ((c[7] ^ bits[i]) ? 9'h007 : 9'h000);
    end
    return c[7:0];
  endfunction

  function automatic logic [17:0] model_chain(input logic [7:0] w0, w1, w2);
    logic [23:0] all;
    all = {w2, w1, w0};
    return all[17:0];
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, cfg_ready, 0);
    chk({tag, "_head"},  ccff_head, 0);
    chk({tag, "_clken"}, prog_clk_en, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   err, 0);
  endtask

  task automatic run_load(input vec_t v, input int reset_at);
    logic [7:0] wa[3];
    int         ga[3];
    int         cyc, widx, gap_left, stalls, done_cyc, vstart;
    bit         hs;
    wa[0] = v.w0; wa[1] = v.w1; wa[2] = v.w2;
    ga[0] = v.g0; ga[1] = v.g1; ga[2] = v.g2;
    vstart   = CHAIN_LEN + 2 + v.g0 + v.g1 + v.g2;
    widx     = 0;
    gap_left = ga[0];
    stalls   = 0;
    done_cyc = -1;

    @(negedge prog_clk);
    cyc = 0;
    chk("err_held_idle", err, last_err);
    chk("idle_ready", cfg_ready, 0);
    cfg_start     = 1'b1;
    cfg_verify_en = v.verify;
    cfg_valid     = 1'($urandom % 2);
    cfg_data      = 8'($urandom);
    hs            = cfg_valid && cfg_ready;

    while (cyc < 300) begin
      @(negedge prog_clk);
      cyc++;
      if (hs) begin
        widx++;
        if (widx < 3) gap_left = ga[widx];
      end
      if (cyc == reset_at) begin
        prog_reset_n = 1'b0;
        #1;
        check_zero("mid_reset");
        @(negedge prog_clk);
        @(negedge prog_clk);
        cfg_start    = 1'b0;
        cfg_valid    = 1'b0;
        stuck        = 1'b0;
        prog_reset_n = 1'b1;
        last_err     = 1'b0;
        return;
      end
      cfg_start     = v.busy_start && (cyc == 5);
      cfg_verify_en = cfg_start ? 1'b1 : v.verify;
      stuck         = v.fault && (cyc >= vstart);
      if (cyc == 1) begin
        chk("busy_c1", busy, 1);
        chk("err_clr_c1", err, 0);
      end
      if (widx < 3) begin
        if (cfg_ready) begin
          if (gap_left > 0) begin
            cfg_valid = 1'b0;
            gap_left--;
          end else begin
            cfg_valid = 1'b1;
            cfg_data  = wa[widx];
          end
        end else begin
          cfg_valid = 1'($urandom % 2);
          cfg_data  = 8'($urandom);
        end
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = 8'($urandom);
      end
      hs = cfg_valid && cfg_ready;
      if (busy && !prog_clk_en) stalls++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end

    if (done_cyc < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected cycle %0d", v.exp_done);
    end else begin
      chk("done_cycle", done_cyc, v.exp_done);
      chk("err", err, v.exp_err);
      chk("words_accepted", widx, 3);
      chk("stall_cycles", stalls, 1 + v.g0 + v.g1 + v.g2);
      if (!v.fault) chk("chain", chain, v.exp_chain);
    end
    stuck     = 1'b0;
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
    @(negedge prog_clk);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    chk("err_hold", err, v.exp_err);
    last_err = v.exp_err;
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    prog_reset_n  = 1'b0;
    cfg_start     = 1'b0;
    cfg_verify_en = 1'b0;
    cfg_data      = '0;
    cfg_valid     = 1'b0;
    stuck         = 1'b0;
    last_err      = 1'b0;

    tbl[0] = '{8'hA5, 8'h3C, 8'h02, 0, 0, 0, 1'b0, 1'b0, 1'b0, 20, 18'h23CA5, 1'b0};
    tbl[1] = '{8'hA5, 8'h3C, 8'h02, 0, 0, 0, 1'b1, 1'b0, 1'b0, 38, 18'h23CA5, 1'b0};
    tbl[2] = '{8'hA5, 8'h3C, 8'h02, 0, 0, 0, 1'b1, 1'b1, 1'b0, 38, 18'h00000, 1'b1};
    tbl[3] = '{8'hA5, 8'h3C, 8'h02, 0, 3, 0, 1'b0, 1'b0, 1'b0, 23, 18'h23CA5, 1'b0};
    tbl[4] = '{8'hA5, 8'h3C, 8'h02, 0, 3, 0, 1'b1, 1'b0, 1'b1, 41, 18'h23CA5, 1'b0};
    tbl[5] = '{8'hFF, 8'h00, 8'hFF, 2, 0, 1, 1'b1, 1'b0, 1'b0, 41, 18'h300FF, 1'b0};

    repeat (3) @(negedge prog_clk);
    check_zero("reset");
    prog_reset_n = 1'b1;
    @(negedge prog_clk);

    for (int i = 0; i < 6; i++) begin
      run_load(tbl[i], -1);
      if (i == 2) repeat (3) @(negedge prog_clk);
    end

    run_load(tbl[1], 10);
    run_load(tbl[1], -1);

    for (int i = 0; i < 25; i++) begin
      rv.w0         = 8'($urandom);
      rv.w1         = 8'($urandom);
      rv.w2         = 8'($urandom);
      rv.g0         = $urandom_range(0, 3);
      rv.g1         = $urandom_range(0, 3);
      rv.g2         = $urandom_range(0, 3);
      rv.verify     = 1'($urandom % 2);
      rv.fault      = rv.verify && ($urandom % 4 == 0);
      rv.busy_start = 1'($urandom % 2);
      rv.exp_done   = CHAIN_LEN + 2 + rv.g0 + rv.g1 + rv.g2 + (rv.verify ? CHAIN_LEN : 0);
      rv.exp_chain  = model_chain(rv.w0, rv.w1, rv.w2);
      rv.exp_err    = rv.fault && (model_crc(18'h3FFFF) != model_crc(rv.exp_chain));
      run_load(rv, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
